// File: rtl/multichannel_audio_buffer_if.sv
// Bus slave interface for multichannel_audio_buffer.
//
// Signals:
//   chipselect, read, write : bus strobes, one cycle per access
//   address [2:0]           : register select
//   writedata [31:0]        : write data (master -> slave)
//   readdata [31:0]         : registered read data (slave -> master)
//
// Handshake: there is no back-pressure. Every access whose strobes
// (chipselect & read, or chipselect & write) are high at a rising clock
// edge is accepted on that edge. Read data appears on readdata in the
// following cycle and stays there until the next read is accepted.
interface multichannel_audio_buffer_if;
  logic        chipselect;
  logic        read;
  logic        write;
  logic [2:0]  address;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output chipselect, read, write, address, writedata,
    input  readdata
  );

  modport slave (
    input  chipselect, read, write, address, writedata,
    output readdata
  );
endinterface

// File: rtl/multichannel_audio_buffer.sv
// Multichannel audio buffer between codec sample strobes and a CPU bus.
// Each channel has one input FIFO (codec -> CPU) and one output FIFO
// (CPU -> codec), 2^DEPTH_LOG2 entries deep. Input capture is frame
// aligned: when any input FIFO is full at the start of a frame, the whole
// frame is dropped so channels never misalign. The output side supports
// mute, feedback and CPU modes, with a selectable underrun policy.
//
// Ports:
//   system_clk, system_reset : sole clock, synchronous active-high reset
//   bus                      : bus slave (see multichannel_audio_buffer_if)
//   sample_end[c]            : audio_input slice c valid this cycle
//   sample_req[c]            : codec consumes audio_output slice c
//   audio_input/audio_output : channel c at [c*SAMPLE_W +: SAMPLE_W]
//
// Register map:
//   0 W: push sample to output FIFO wr_ch    R: {out_free_min, in_level_min}
//   1 R: pop input FIFO rd_ch (0 if empty)
//   2 RW: ctrl[3:0] = {capture_en, hold_on_underrun, mode[1:0]}
//   3 R: {underrun_cnt, overflow_cnt}        W: clear both counters
//   4 W: flush all FIFOs, zero wr_ch/rd_ch
module multichannel_audio_buffer #(
  parameter int CHANNELS   = 2,
  parameter int SAMPLE_W   = 16,
  parameter int DEPTH_LOG2 = 9
) (
  input  logic                         system_clk,
  input  logic                         system_reset,
  multichannel_audio_buffer_if.slave   bus,
  input  logic [CHANNELS-1:0]          sample_end,
  input  logic [CHANNELS-1:0]          sample_req,
  input  logic [CHANNELS*SAMPLE_W-1:0] audio_input,
  output logic [CHANNELS*SAMPLE_W-1:0] audio_output
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int LW    = DEPTH_LOG2 + 1;

  typedef logic [SAMPLE_W-1:0]   sample_t;
  typedef logic [LW-1:0]         level_t;
  typedef logic [DEPTH_LOG2-1:0] ptr_t;

  sample_t in_mem  [CHANNELS][DEPTH];
  sample_t out_mem [CHANNELS][DEPTH];
  ptr_t    in_wp   [CHANNELS];
  ptr_t    in_rp   [CHANNELS];
  ptr_t    out_wp  [CHANNELS];
  ptr_t    out_rp  [CHANNELS];
  level_t  in_lvl  [CHANNELS];
  level_t  out_lvl [CHANNELS];
  sample_t last_in [CHANNELS];

  logic [3:0]      ctrl;
  logic [15:0]     overflow_cnt;
  logic [15:0]     underrun_cnt;
  logic [CH_W-1:0] wr_ch;
  logic [CH_W-1:0] rd_ch;
  logic            frame_drop;

  logic wr_cyc, rd_cyc, flush, cnt_clear, cpu_mode;
  assign wr_cyc    = bus.chipselect & bus.write;
  assign rd_cyc    = bus.chipselect & bus.read;
  assign flush     = wr_cyc && (bus.address == 3'd4);
  assign cnt_clear = wr_cyc && (bus.address == 3'd3);
  assign cpu_mode  = ctrl[1];

  // Upper write-data bits carry nothing.
  logic unused_wdata;
  assign unused_wdata = ^bus.writedata[31:SAMPLE_W];

  logic [CHANNELS-1:0] in_full, in_empty, out_full, out_empty;
  logic [CHANNELS-1:0] in_push, in_pop, out_push, out_pop, underrun;
  logic                frame_drop_eff;
  level_t              in_min, out_free_min;
  logic [3:0]          underrun_n;
  logic [16:0]         ur_sum;
  logic [31:0]         rd_data;

  always_comb begin
    in_full        = '0;
    in_empty       = '0;
    out_full       = '0;
    out_empty      = '0;
    in_push        = '0;
    in_pop         = '0;
    out_push       = '0;
    out_pop        = '0;
    underrun       = '0;
    underrun_n     = '0;
    in_min         = in_lvl[0];
    out_free_min   = level_t'(DEPTH) - out_lvl[0];
    for (int c = 0; c < CHANNELS; c++) begin
      in_full[c]   = (in_lvl[c] == level_t'(DEPTH));
      in_empty[c]  = (in_lvl[c] == '0);
      out_full[c]  = (out_lvl[c] == level_t'(DEPTH));
      out_empty[c] = (out_lvl[c] == '0);
      if (in_lvl[c] < in_min) in_min = in_lvl[c];
      if (level_t'(DEPTH) - out_lvl[c] < out_free_min)
        out_free_min = level_t'(DEPTH) - out_lvl[c];
    end
    // The frame decision uses the fresh value on the frame-opening cycle.
    frame_drop_eff = sample_end[0] ? (|in_full) : frame_drop;
    for (int c = 0; c < CHANNELS; c++) begin
      in_push[c]  = sample_end[c] & ctrl[3] & ~frame_drop_eff & ~in_full[c] & ~flush;
      in_pop[c]   = rd_cyc && (bus.address == 3'd1) && (rd_ch == CH_W'(c))
                    && !in_empty[c] && !flush;
      out_push[c] = wr_cyc && (bus.address == 3'd0) && (wr_ch == CH_W'(c))
                    && !out_full[c] && !flush;
      out_pop[c]  = sample_req[c] & cpu_mode & ~out_empty[c] & ~flush;
      underrun[c] = sample_req[c] & cpu_mode & out_empty[c];
      underrun_n  = underrun_n + 4'(underrun[c]);
    end
    ur_sum = {1'b0, underrun_cnt} + 17'(underrun_n);
  end

  // Read mux; all values are pre-edge state.
  always_comb begin
    rd_data = '0;
    case (bus.address)
      3'd0: rd_data = {16'(out_free_min), 16'(in_min)};
      3'd1: for (int c = 0; c < CHANNELS; c++)
              if (in_pop[c]) rd_data = 32'(in_mem[c][in_rp[c]]);
      3'd2: rd_data = {28'd0, ctrl};
      3'd3: rd_data = {underrun_cnt, overflow_cnt};
      default: rd_data = '0;
    endcase
  end

  // FIFO storage carries no reset; levels and pointers define validity.
  always_ff @(posedge system_clk) begin
    for (int c = 0; c < CHANNELS; c++) begin
      if (in_push[c])  in_mem[c][in_wp[c]]   <= audio_input[c*SAMPLE_W +: SAMPLE_W];
      if (out_push[c]) out_mem[c][out_wp[c]] <= bus.writedata[SAMPLE_W-1:0];
    end
  end

  always_ff @(posedge system_clk) begin
    if (system_reset || flush) begin
      for (int c = 0; c < CHANNELS; c++) begin
        in_wp[c]   <= '0;
        in_rp[c]   <= '0;
        out_wp[c]  <= '0;
        out_rp[c]  <= '0;
        in_lvl[c]  <= '0;
        out_lvl[c] <= '0;
      end
      wr_ch <= '0;
      rd_ch <= '0;
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (in_push[c])  in_wp[c]  <= in_wp[c]  + ptr_t'(1);
        if (in_pop[c])   in_rp[c]  <= in_rp[c]  + ptr_t'(1);
        if (out_push[c]) out_wp[c] <= out_wp[c] + ptr_t'(1);
        if (out_pop[c])  out_rp[c] <= out_rp[c] + ptr_t'(1);
        in_lvl[c]  <= in_lvl[c]  + level_t'(in_push[c])  - level_t'(in_pop[c]);
        out_lvl[c] <= out_lvl[c] + level_t'(out_push[c]) - level_t'(out_pop[c]);
      end
      if (|out_push) wr_ch <= (wr_ch == CH_W'(CHANNELS-1)) ? '0 : wr_ch + CH_W'(1);
      if (|in_pop)   rd_ch <= (rd_ch == CH_W'(CHANNELS-1)) ? '0 : rd_ch + CH_W'(1);
    end
  end

  always_ff @(posedge system_clk) begin
    if (system_reset) begin
      ctrl         <= '0;
      overflow_cnt <= '0;
      underrun_cnt <= '0;
      frame_drop   <= 1'b0;
      audio_output <= '0;
      bus.readdata <= '0;
      for (int c = 0; c < CHANNELS; c++) last_in[c] <= '0;
    end else begin
      if (wr_cyc && (bus.address == 3'd2)) ctrl <= bus.writedata[3:0];
      if (sample_end[0]) frame_drop <= |in_full;

      // Clear beats a same-cycle increment; both counters saturate.
      if (cnt_clear) begin
        overflow_cnt <= '0;
        underrun_cnt <= '0;
      end else begin
        if (sample_end[0] && (|in_full) && overflow_cnt != 16'hFFFF)
          overflow_cnt <= overflow_cnt + 16'd1;
        underrun_cnt <= ur_sum[16] ? 16'hFFFF : ur_sum[15:0];
      end

      for (int c = 0; c < CHANNELS; c++) begin
        if (sample_end[c]) last_in[c] <= audio_input[c*SAMPLE_W +: SAMPLE_W];
        if (sample_req[c]) begin
          if (ctrl[1:0] == 2'd0)
            audio_output[c*SAMPLE_W +: SAMPLE_W] <= '0;
          else if (ctrl[1:0] == 2'd1)
            audio_output[c*SAMPLE_W +: SAMPLE_W] <= last_in[c];
          else if (!out_empty[c])
            audio_output[c*SAMPLE_W +: SAMPLE_W] <= out_mem[c][out_rp[c]];
          else if (!ctrl[2])
            audio_output[c*SAMPLE_W +: SAMPLE_W] <= '0;
        end
      end

      if (rd_cyc) bus.readdata <= rd_data;
    end
  end
endmodule

// File: doc/multichannel_audio_buffer.md
# multichannel_audio_buffer

Parametrised single-clock audio buffer between the codec sample strobes and the CPU bus slave, generalising the two-channel stereo channel buffer to CHANNELS interleaved channels of SAMPLE_W bits. It holds one input FIFO (codec to CPU) and one output FIFO (CPU to codec) per channel, each 2^DEPTH_LOG2 deep. It also adds three things:
- frame-aligned overflow handling on the input side;
- a selectable underrun policy on the output side;
- overflow/underrun counters readable by software.

## Interface
Parameters:
- CHANNELS, 2: channel count, 1..8; channel 0 is first in each frame.
- SAMPLE_W, 16: sample width, 8..16.
- DEPTH_LOG2, 9: log2 of per-channel FIFO depth; levels are DEPTH_LOG2+1 bits, zero-extended to 16.

Ports:
- system_clk  in  1  sole clock; codec strobes are already synchronous to it.
- system_reset  in  1  reset, synchronous, active-high.
- chipselect, read, write  in  1 each  bus slave strobes.
- address  in  3  register select.
- writedata  in  32  bus write data.
- readdata  out  32  registered bus read data.
- sample_end  in  CHANNELS  one-cycle pulse per channel: audio_input slice c is valid.
- sample_req  in  CHANNELS  one-cycle pulse per channel: codec takes audio_output slice c.
- audio_input  in  CHANNELS*SAMPLE_W  channel c occupies bits [c*SAMPLE_W +: SAMPLE_W].
- audio_output  out  CHANNELS*SAMPLE_W  same packing as audio_input.

## Operation
Register map. The low SAMPLE_W bits of writedata/readdata carry samples; all other sample bits are zero.
- Address 0, write: push to the output FIFO of channel wr_ch, then wr_ch advances by 1 mod CHANNELS. If that FIFO is full, the write is dropped and wr_ch holds.
- Address 0, read: {out_free_min[15:0], in_level_min[15:0]}, each the minimum across all channels.
- Address 1, read: pop the input FIFO of channel rd_ch and return its head, then rd_ch advances. If that FIFO is empty, return 0 and rd_ch holds.
- Address 2, read/write: control register ctrl[3:0].
  - [1:0] mode: 0 mute, 1 feedback, 2 or 3 CPU.
  - [2] hold_on_underrun.
  - [3] capture_en.
- Address 3, read: {underrun_cnt[15:0], overflow_cnt[15:0]}. Any write clears both counters.
- Address 4, write: flush all FIFOs and zero wr_ch and rd_ch. Counters and ctrl are kept.
- Other addresses: reads return 0, writes are ignored.

Input path:
- sample_end[c] always latches slice c into last_in[c].
- sample_end[0] opens a frame: frame_drop <= any input FIFO full.
- If capture_en and !frame_drop(effective), slice c is pushed to input FIFO c.
- If frame_drop(effective) is 1 (the fresh value on the sample_end[0] cycle itself), nothing in the frame is pushed, and on the sample_end[0] cycle overflow_cnt increments once.
- The flag holds until the next sample_end[0], so channels never misalign.

Output path, on sample_req[c]:
- Mute: slice c <= 0.
- Feedback: slice c <= last_in[c].
- CPU, FIFO c non-empty: pop it; slice c <= head.
- CPU, FIFO c empty: this is an underrun. underrun_cnt increments, and slice c holds its value if hold_on_underrun, else goes to 0.
- Each channel is independent; multiple pulses in one cycle are all serviced, and the underrun counter adds 1 per affected channel.

Boundaries:
- A bus push and an audio pop on the same FIFO in the same cycle both occur.
- A bus pop and an audio push on the same FIFO in the same cycle both occur.
- Counters saturate at 0xFFFF.
- A clear write in the same cycle as an increment: clear wins.
- A flush in the same cycle as a push or pop: flush wins.
- Reads of address 0 report pre-edge levels.

## Timing
- Reset: readdata, audio_output, ctrl, counters, wr_ch, rd_ch, frame_drop, last_in and all FIFO levels go to 0. Reset mid-operation discards all buffered data.
- readdata loads on the edge where chipselect&read is sampled, is valid the following cycle, and holds until the next read.
- Writes take effect at the sampling edge; a new level is visible to a read issued the next cycle.
- audio_output slice c updates on the edge sampling sample_req[c], so it is valid one cycle after the pulse.
- Input samples are poppable by the bus one cycle after their sample_end edge.
- No back-pressure: the bus is never stalled.

## Test plan
- CHANNELS=4, CPU mode, with 8 interleaved writes 0x11..0x18 -> sample_req sweeps over ch0..3 twice output 0x11,0x12,0x13,0x14 then 0x15..0x18; out_free_min = DEPTH-2 after the writes.
- Fill input FIFO 2 to DEPTH, then one full frame of sample_end pulses -> no channel pushed, overflow_cnt=1, in_level of all others unchanged; the next frame after one bus frame-read is captured normally.
- CPU mode with the output FIFO empty and hold_on_underrun=1 and last output 0x7FFF -> output stays 0x7FFF, underrun_cnt=1. Repeat with hold=0 -> output 0x0000, underrun_cnt=2.
- Feedback mode: sample_end[1] with input 0x1234, then sample_req[1] -> slice 1 = 0x1234 one cycle later; the output FIFO is not popped.
- Write counter clear in the same cycle as an underrun -> counters read 0. Drive 70000 underruns -> underrun_cnt=0xFFFF.
- Assert system_reset mid-stream with FIFOs half full -> all levels 0, readdata=0, audio_output=0, wr_ch=rd_ch=0; the first post-reset write lands in channel 0.
